// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with an integrated busy scoreboard.
// Reads use one cycle of address latency; writes have a fixed port priority.
// Register 0 always reads as zero and can never be marked busy.
//
// Ports:
//   clock_i      rising-edge clock
//   reset_i      asynchronous active-high reset; clears registers, busy bits, read addresses
//   raddr_i      NUM_RD read addresses, port p at [p*AW +: AW], captured at posedge
//   rdata_o      NUM_RD read data, port p at [p*XLEN +: XLEN], from the latched address
//   rbusy_o      per read port busy bit of the register at the latched address
//   waddr_i      NUM_WR write addresses
//   wdata_i      NUM_WR write data
//   wen_i        NUM_WR write enables; a write also releases the register's busy bit
//   resv_addr_i  NUM_WR destination registers to reserve, one per issue lane
//   resv_en_i    NUM_WR reserve strobes
//   busy_o       full scoreboard vector; bit 0 is always 0
module regfile_mp #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned NUM_RD = 4,
  parameter int unsigned NUM_WR = 2
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic [NUM_RD*AW-1:0]     raddr_i,
  output logic [NUM_RD*XLEN-1:0]   rdata_o,
  output logic [NUM_RD-1:0]        rbusy_o,
  input  logic [NUM_WR*AW-1:0]     waddr_i,
  input  logic [NUM_WR*XLEN-1:0]   wdata_i,
  input  logic [NUM_WR-1:0]        wen_i,
  input  logic [NUM_WR*AW-1:0]     resv_addr_i,
  input  logic [NUM_WR-1:0]        resv_en_i,
  output logic [NREGS-1:0]         busy_o
);

  logic [XLEN-1:0]      regs_q [NREGS];
  logic [XLEN-1:0]      regs_d [NREGS];
  logic [NREGS-1:0]     busy_q;
  logic [NREGS-1:0]     busy_d;
  logic [NUM_RD*AW-1:0] raddr_q;

  // Next-state of array and scoreboard; later write ports override earlier ones.
  always_comb begin
    logic set_v;
    logic clr_v;
    regs_d = regs_q;
    busy_d = busy_q;
    set_v  = 1'b0;
    clr_v  = 1'b0;
    for (int r = 1; r < int'(NREGS); r++) begin
      set_v = 1'b0;
      clr_v = 1'b0;
      for (int q = 0; q < int'(NUM_WR); q++) begin
        if (wen_i[q] && (waddr_i[q*AW +: AW] == AW'(r))) begin
          regs_d[r] = wdata_i[q*XLEN +: XLEN];
          clr_v     = 1'b1;
        end
        if (resv_en_i[q] && (resv_addr_i[q*AW +: AW] == AW'(r))) begin
          set_v = 1'b1;
        end
      end
      // A new producer issued in the same cycle an old one retires keeps the register busy.
      busy_d[r] = set_v | (busy_q[r] & ~clr_v);
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  // State registers: array, scoreboard and latched read addresses.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int r = 0; r < int'(NREGS); r++) begin
        regs_q[r] <= '0;
      end
      busy_q  <= '0;
      raddr_q <= '0;
    end else begin
      for (int r = 0; r < int'(NREGS); r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q  <= busy_d;
      raddr_q <= raddr_i;
    end
  end

  // Read ports: combinational lookup from the latched address, so a write at the
  // capture edge is already visible (write-first).
  for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra                        = raddr_q[p*AW +: AW];
    assign rdata_o[p*XLEN +: XLEN]   = (ra == '0) ? '0 : regs_q[ra];
    assign rbusy_o[p]                = busy_q[ra];
  end

  assign busy_o = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp (default parameters).
module tb_regfile_mp;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned AW     = 5;
  localparam int unsigned NUM_RD = 4;
  localparam int unsigned NUM_WR = 2;

  logic                   clock_i;
  logic                   reset_i;
  logic [NUM_RD*AW-1:0]   raddr_i;
  logic [NUM_RD*XLEN-1:0] rdata_o;
  logic [NUM_RD-1:0]      rbusy_o;
  logic [NUM_WR*AW-1:0]   waddr_i;
  logic [NUM_WR*XLEN-1:0] wdata_i;
  logic [NUM_WR-1:0]      wen_i;
  logic [NUM_WR*AW-1:0]   resv_addr_i;
  logic [NUM_WR-1:0]      resv_en_i;
  logic [NREGS-1:0]       busy_o;

  int checks = 0;
  int errors = 0;

  regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)
  ) dut (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .raddr_i    (raddr_i),
    .rdata_o    (rdata_o),
    .rbusy_o    (rbusy_o),
    .waddr_i    (waddr_i),
    .wdata_i    (wdata_i),
    .wen_i      (wen_i),
    .resv_addr_i(resv_addr_i),
    .resv_en_i  (resv_en_i),
    .busy_o     (busy_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  // Advance one edge and land 1ns after it, away from the active edge.
  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic idle_inputs();
    waddr_i     = '0;
    wdata_i     = '0;
    wen_i       = '0;
    resv_addr_i = '0;
    resv_en_i   = '0;
  endtask

  task automatic read_all(input logic [AW-1:0] a);
    raddr_i = {NUM_RD{a}};
  endtask

  task automatic test_reset();
    logic [XLEN-1:0] d;
    reset_i = 1'b0;
    idle_inputs();
    read_all(5'd0);
    #1 reset_i = 1'b1;
    step();
    read_all(5'd17);
    step();
    checks++;
    if (rdata_o !== '0) begin
      errors++; $display("FAIL reset_rdata actual=%h required=0", rdata_o);
    end
    checks++;
    if (busy_o !== '0 || rbusy_o !== '0) begin
      errors++; $display("FAIL reset_busy actual=%h/%b required=0", busy_o, rbusy_o);
    end
    #2 reset_i = 1'b0;
    // Each port reads a different register; cover all 32 over 8 cycles.
    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < int'(NUM_RD); p++) begin
        raddr_i[p*AW +: AW] = AW'(i * int'(NUM_RD) + p);
      end
      step();
      for (int p = 0; p < int'(NUM_RD); p++) begin
        d = rdata_o[p*XLEN +: XLEN];
        checks++;
        if (d !== '0) begin
          errors++; $display("FAIL reset_read r%0d actual=%h required=0", i * int'(NUM_RD) + p, d);
        end
      end
    end
    checks++;
    if (busy_o !== '0) begin
      errors++; $display("FAIL reset_busy_after actual=%h required=0", busy_o);
    end
  endtask

  task automatic test_write_first();
    logic [XLEN-1:0] d;
    idle_inputs();
    waddr_i[0 +: AW]   = 5'd5;
    wdata_i[0 +: XLEN] = 32'hDEADBEEF;
    wen_i              = 2'b01;
    read_all(5'd5);
    step();
    idle_inputs();
    for (int p = 0; p < int'(NUM_RD); p++) begin
      d = rdata_o[p*XLEN +: XLEN];
      checks++;
      if (d !== 32'hDEADBEEF) begin
        errors++; $display("FAIL write_first port%0d actual=%h required=deadbeef", p, d);
      end
    end
    checks++;
    if (rbusy_o !== '0) begin
      errors++; $display("FAIL write_first_rbusy actual=%b required=0", rbusy_o);
    end
  endtask

  task automatic test_write_priority();
    idle_inputs();
    waddr_i = {5'd7, 5'd7};
    wdata_i = {32'h00000022, 32'h00000011};
    wen_i   = 2'b11;
    read_all(5'd7);
    raddr_i[1*AW +: AW] = 5'd5;
    step();
    idle_inputs();
    checks++;
    if (rdata_o[0 +: XLEN] !== 32'h22) begin
      errors++; $display("FAIL prio_r7 actual=%h required=00000022", rdata_o[0 +: XLEN]);
    end
    checks++;
    if (rdata_o[1*XLEN +: XLEN] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL prio_r5_kept actual=%h required=deadbeef", rdata_o[1*XLEN +: XLEN]);
    end
    // Distinct addresses on both ports must both land.
    waddr_i = {5'd12, 5'd11};
    wdata_i = {32'hCAFE0012, 32'hCAFE0011};
    wen_i   = 2'b11;
    raddr_i = {5'd7, 5'd5, 5'd12, 5'd11};
    step();
    idle_inputs();
    checks++;
    if (rdata_o !== {32'h22, 32'hDEADBEEF, 32'hCAFE0012, 32'hCAFE0011}) begin
      errors++; $display("FAIL dual_write actual=%h required=00000022deadbeefcafe0012cafe0011", rdata_o);
    end
  endtask

  task automatic test_reg0();
    idle_inputs();
    waddr_i[0 +: AW]      = 5'd0;
    wdata_i[0 +: XLEN]    = 32'hFFFFFFFF;
    wen_i                 = 2'b01;
    resv_addr_i[1*AW +: AW] = 5'd0;
    resv_en_i             = 2'b10;
    read_all(5'd0);
    step();
    idle_inputs();
    step();
    checks++;
    if (rdata_o !== '0) begin
      errors++; $display("FAIL reg0_read actual=%h required=0", rdata_o);
    end
    checks++;
    if (busy_o !== '0 || rbusy_o !== '0) begin
      errors++; $display("FAIL reg0_busy actual=%h/%b required=0", busy_o, rbusy_o);
    end
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    resv_addr_i[0 +: AW] = 5'd3;
    resv_en_i            = 2'b01;
    read_all(5'd3);
    step();
    idle_inputs();
    checks++;
    if (busy_o !== 32'h00000008 || rbusy_o !== 4'hF) begin
      errors++; $display("FAIL sb_reserve actual=%h/%b required=00000008/1111", busy_o, rbusy_o);
    end
    // Reserve on lane 1 and write on port 0 at the same edge: set beats clear.
    resv_addr_i[1*AW +: AW] = 5'd3;
    resv_en_i               = 2'b10;
    waddr_i[0 +: AW]        = 5'd3;
    wdata_i[0 +: XLEN]      = 32'h33;
    wen_i                   = 2'b01;
    step();
    idle_inputs();
    checks++;
    if (busy_o !== 32'h00000008) begin
      errors++; $display("FAIL sb_set_beats_clear actual=%h required=00000008", busy_o);
    end
    checks++;
    if (rdata_o[0 +: XLEN] !== 32'h33) begin
      errors++; $display("FAIL sb_write_data actual=%h required=00000033", rdata_o[0 +: XLEN]);
    end
    waddr_i[1*AW +: AW]   = 5'd3;
    wdata_i[1*XLEN +: XLEN] = 32'h34;
    wen_i                 = 2'b10;
    step();
    idle_inputs();
    checks++;
    if (busy_o !== '0 || rbusy_o !== '0) begin
      errors++; $display("FAIL sb_release actual=%h/%b required=0", busy_o, rbusy_o);
    end
    // Two lanes reserve different registers, then retire crosswise.
    resv_addr_i = {5'd11, 5'd10};
    resv_en_i   = 2'b11;
    raddr_i     = {5'd0, 5'd3, 5'd11, 5'd10};
    step();
    idle_inputs();
    checks++;
    if (busy_o !== 32'h00000C00 || rbusy_o !== 4'b0011) begin
      errors++; $display("FAIL sb_two_lanes actual=%h/%b required=00000c00/0011", busy_o, rbusy_o);
    end
    waddr_i = {5'd10, 5'd11};
    wen_i   = 2'b11;
    step();
    idle_inputs();
    checks++;
    if (busy_o !== '0) begin
      errors++; $display("FAIL sb_cross_release actual=%h required=0", busy_o);
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    waddr_i[0 +: AW]     = 5'd9;
    wdata_i[0 +: XLEN]   = 32'h55;
    wen_i                = 2'b01;
    step();
    idle_inputs();
    resv_addr_i[0 +: AW] = 5'd9;
    resv_en_i            = 2'b01;
    read_all(5'd9);
    step();
    idle_inputs();
    checks++;
    if (rdata_o[0 +: XLEN] !== 32'h55 || busy_o !== 32'h00000200) begin
      errors++; $display("FAIL mid_setup actual=%h/%h required=00000055/00000200", rdata_o[0 +: XLEN], busy_o);
    end
    #2 reset_i = 1'b1;
    #1;
    checks++;
    if (rdata_o !== '0 || busy_o !== '0 || rbusy_o !== '0) begin
      errors++; $display("FAIL mid_async actual=%h/%h/%b required=0", rdata_o, busy_o, rbusy_o);
    end
    // Writes presented while reset is held must be dropped.
    waddr_i[0 +: AW]   = 5'd9;
    wdata_i[0 +: XLEN] = 32'h77;
    wen_i              = 2'b01;
    step();
    #2;
    reset_i = 1'b0;
    idle_inputs();
    read_all(5'd9);
    step();
    checks++;
    if (rdata_o !== '0 || busy_o !== '0) begin
      errors++; $display("FAIL mid_after actual=%h/%h required=0", rdata_o, busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_write_first();
    test_write_priority();
    test_reg0();
    test_scoreboard();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
